// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch/decode/exec/mem/wb
// one instruction at a time and drives datapath selects, enables and trap flags.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        illegal,
    output logic        timeout,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_NONE   = 4'd0,
        C_LUI    = 4'd1,
        C_AUIPC  = 4'd2,
        C_JAL    = 4'd3,
        C_JALR   = 4'd4,
        C_BRANCH = 4'd5,
        C_LOAD   = 4'd6,
        C_STORE  = 4'd7,
        C_OPIMM  = 4'd8,
        C_OP     = 4'd9,
        C_FENCE  = 4'd10,
        C_SYSTEM = 4'd11
    } class_t;

    // Last count value before the limit; the trap fires on the cycle that would reach MEM_TIMEOUT.
    localparam logic [TO_W-1:0] LP_TO_LAST = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
    localparam bit              LP_TO_EN   = (MEM_TIMEOUT != 0);

    state_t            r_state;
    class_t            r_class;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_illegal;
    logic              r_timeout;

    class_t            w_dec_class;
    logic              w_to_hit;
    logic              w_unused_inst;

    assign w_unused_inst = ^inst[31:7];

    always_comb begin
        w_dec_class = C_NONE;
        case (inst[6:0])
            7'b0110111: w_dec_class = C_LUI;
            7'b0010111: w_dec_class = C_AUIPC;
            7'b1101111: w_dec_class = C_JAL;
            7'b1100111: w_dec_class = C_JALR;
            7'b1100011: w_dec_class = C_BRANCH;
            7'b0000011: w_dec_class = C_LOAD;
            7'b0100011: w_dec_class = C_STORE;
            7'b0010011: w_dec_class = C_OPIMM;
            7'b0110011: w_dec_class = C_OP;
            7'b0001111: w_dec_class = C_FENCE;
            7'b1110011: w_dec_class = C_SYSTEM;
            default:    w_dec_class = C_NONE;
        endcase
    end

    assign w_to_hit = LP_TO_EN && !mem_ready && (r_to_cnt == LP_TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_class   <= C_NONE;
            r_to_cnt  <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state  <= S_FETCH;
                    r_to_cnt <= '0;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_to_hit) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_TRAP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    r_class <= w_dec_class;
                    if (w_dec_class == C_NONE) begin
                        r_illegal <= 1'b1;
                        r_state   <= S_TRAP;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (r_class)
                        C_BRANCH: begin
                            r_state  <= S_FETCH;
                            r_to_cnt <= '0;
                        end
                        C_LOAD, C_STORE: begin
                            r_state  <= S_MEM;
                            r_to_cnt <= '0;
                        end
                        default: r_state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (r_class == C_STORE) begin
                            r_state  <= S_FETCH;
                            r_to_cnt <= '0;
                        end else begin
                            r_state <= S_WB;
                        end
                    end else if (w_to_hit) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_TRAP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_WB, S_TRAP: begin
                    r_state  <= S_FETCH;
                    r_to_cnt <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from the state register so an async reset drops them at once.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        rf_we        = 1'b0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 1'b0;
        wb_sel       = 2'd0;
        retire       = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_EXEC: begin
                case (r_class)
                    C_OP: begin
                        alu_a_sel = 2'd0;
                        alu_b_sel = 1'b0;
                    end
                    C_OPIMM, C_LOAD, C_STORE, C_JALR: begin
                        alu_a_sel = 2'd0;
                        alu_b_sel = 1'b1;
                    end
                    C_LUI: begin
                        alu_a_sel = 2'd2;
                        alu_b_sel = 1'b1;
                    end
                    C_AUIPC, C_JAL: begin
                        alu_a_sel = 2'd1;
                        alu_b_sel = 1'b1;
                    end
                    C_BRANCH: begin
                        alu_a_sel = 2'd1;
                        alu_b_sel = 1'b1;
                        pc_we     = 1'b1;
                        pc_sel    = {1'b0, br_taken};
                        retire    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (r_class == C_STORE);
                if (mem_ready && (r_class == C_STORE)) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            S_WB: begin
                pc_we  = 1'b1;
                retire = 1'b1;
                rf_we  = !((r_class == C_FENCE) || (r_class == C_SYSTEM));
                if (r_class == C_LOAD) begin
                    wb_sel = 2'd1;
                end else if ((r_class == C_JAL) || (r_class == C_JALR)) begin
                    wb_sel = 2'd2;
                end
                if ((r_class == C_JAL) || (r_class == C_JALR)) begin
                    pc_sel = 2'd1;
                end
            end
            S_TRAP: begin
                pc_we  = 1'b1;
                pc_sel = 2'd2;
            end
            default: ;
        endcase
    end

    assign illegal = r_illegal;
    assign timeout = r_timeout;
    assign state   = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-instruction cycle-sequence model builds the
// expected output trace, and one compare process checks the DUT every cycle.
module tb_multicycle_ctrl;

    localparam int unsigned MEM_TO = 4;

    localparam int K_ILL = 0, K_LUI = 1, K_AUIPC = 2, K_JAL = 3, K_JALR = 4, K_BR = 5;
    localparam int K_LD = 6, K_ST = 7, K_OPI = 8, K_OP = 9, K_FEN = 10, K_SYS = 11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = '0;
    logic        mem_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, alu_b_sel;
    logic        retire, illegal, timeout;
    logic [1:0]  pc_sel, alu_a_sel, wb_sel;
    logic [2:0]  state;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(MEM_TO), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ready(mem_ready), .br_taken(br_taken),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .wb_sel(wb_sel), .retire(retire), .illegal(illegal),
        .timeout(timeout), .state(state)
    );

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic [1:0] alu_a_sel;
        logic       alu_b_sel;
        logic [1:0] wb_sel;
        logic       retire;
        logic       illegal;
        logic       timeout;
    } out_t;

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic        rdy;
        logic        br;
        out_t        exp;
        out_t        mask;
        logic        lit_en;
        out_t        lit;
        logic        mid_rst;
        int          id;
    } rec_t;

    out_t dut_o;
    assign dut_o = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we,
                    alu_a_sel, alu_b_sel, wb_sel, retire, illegal, timeout};

    rec_t q[$];
    rec_t cur;
    logic cur_valid = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   id_ctr = 0;
    logic ill_s = 1'b0;
    logic to_s = 1'b0;

    function automatic rec_t mk(input logic [2:0] st, input logic [31:0] ins, input logic rdy);
        rec_t r;
        r.rst = 1'b1; r.ins = ins; r.rdy = rdy; r.br = 1'b0;
        r.exp = '0; r.exp.state = st; r.exp.illegal = ill_s; r.exp.timeout = to_s;
        r.mask = '1; r.lit_en = 1'b0; r.lit = '0; r.mid_rst = 1'b0; r.id = id_ctr;
        return r;
    endfunction

    // Fields the rules leave open in a given cycle are masked out of the comparison.
    function automatic void push(input rec_t r, input logic sel_ok, input logic full);
        rec_t t;
        t = r;
        if (!full) begin
            if (!t.exp.mem_req) begin t.mask.mem_we = 1'b0; t.mask.mem_addr_sel = 1'b0; end
            if (!t.exp.pc_we) t.mask.pc_sel = 2'b00;
            if (!t.exp.rf_we) t.mask.wb_sel = 2'b00;
            if (!sel_ok) begin t.mask.alu_a_sel = 2'b00; t.mask.alu_b_sel = 1'b0; end
        end
        q.push_back(t);
    endfunction

    function automatic void set_lit(input out_t l);
        q[$].lit = l;
        q[$].lit_en = 1'b1;
    endfunction

    function automatic void push_trap(input logic [31:0] ins);
        rec_t r;
        r = mk(3'd6, ins, 1'b0);
        r.exp.pc_we = 1'b1; r.exp.pc_sel = 2'd2;
        push(r, 1'b0, 1'b0);
    endfunction

    // Wait cycles of a memory phase; returns 0 if the phase ends in a timeout trap.
    function automatic bit wait_phase(input logic [2:0] st, input int waits, input logic [31:0] ins,
                                      input logic we, input logic addr);
        rec_t r;
        int   nw;
        nw = (MEM_TO != 0 && waits >= int'(MEM_TO)) ? int'(MEM_TO) : waits;
        for (int k = 0; k < nw; k++) begin
            r = mk(st, ins, 1'b0);
            r.exp.mem_req = 1'b1; r.exp.mem_we = we; r.exp.mem_addr_sel = addr;
            push(r, 1'b0, 1'b0);
        end
        if (MEM_TO != 0 && waits >= int'(MEM_TO)) begin
            to_s = 1'b1;
            push_trap(ins);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void push_reset_idle();
        rec_t r;
        ill_s = 1'b0; to_s = 1'b0;
        r = mk(3'd0, 32'h0, 1'b0); r.rst = 1'b0; push(r, 1'b0, 1'b1);
        r = mk(3'd0, 32'h0, 1'b0); push(r, 1'b0, 1'b1);
    endfunction

    function automatic void push_instr(input logic [31:0] ins, input int fw, input int mw,
                                       input logic br, input logic [31:0] late);
        rec_t       r;
        logic [6:0] op;
        int         k;
        logic       sel_ok;
        id_ctr++;
        if (!wait_phase(3'd1, fw, ins, 1'b0, 1'b0)) return;
        r = mk(3'd1, ins, 1'b1); r.exp.mem_req = 1'b1; r.exp.ir_we = 1'b1; push(r, 1'b0, 1'b0);
        r = mk(3'd2, ins, 1'b0); push(r, 1'b0, 1'b0);
        op = ins[6:0];
        case (op)
            7'b0110111: k = K_LUI;   7'b0010111: k = K_AUIPC; 7'b1101111: k = K_JAL;
            7'b1100111: k = K_JALR;  7'b1100011: k = K_BR;    7'b0000011: k = K_LD;
            7'b0100011: k = K_ST;    7'b0010011: k = K_OPI;   7'b0110011: k = K_OP;
            7'b0001111: k = K_FEN;   7'b1110011: k = K_SYS;   default:    k = K_ILL;
        endcase
        if (k == K_ILL) begin
            ill_s = 1'b1;
            push_trap(late);
            return;
        end
        r = mk(3'd3, late, 1'b0);
        r.br = br;
        sel_ok = !(k == K_FEN || k == K_SYS);
        case (k)
            K_OP:                      begin r.exp.alu_a_sel = 2'd0; r.exp.alu_b_sel = 1'b0; end
            K_OPI, K_LD, K_ST, K_JALR: begin r.exp.alu_a_sel = 2'd0; r.exp.alu_b_sel = 1'b1; end
            K_LUI:                     begin r.exp.alu_a_sel = 2'd2; r.exp.alu_b_sel = 1'b1; end
            default:                   begin r.exp.alu_a_sel = 2'd1; r.exp.alu_b_sel = 1'b1; end
        endcase
        if (k == K_BR) begin
            r.exp.pc_we = 1'b1; r.exp.pc_sel = {1'b0, br}; r.exp.retire = 1'b1;
            push(r, 1'b1, 1'b0);
            return;
        end
        push(r, sel_ok, 1'b0);
        if (k == K_LD || k == K_ST) begin
            if (!wait_phase(3'd4, mw, late, (k == K_ST), 1'b1)) return;
            r = mk(3'd4, late, 1'b1);
            r.exp.mem_req = 1'b1; r.exp.mem_addr_sel = 1'b1; r.exp.mem_we = (k == K_ST);
            if (k == K_ST) begin
                r.exp.pc_we = 1'b1; r.exp.retire = 1'b1;
                push(r, 1'b0, 1'b0);
                return;
            end
            push(r, 1'b0, 1'b0);
        end
        r = mk(3'd5, late, 1'b0);
        r.exp.pc_we = 1'b1; r.exp.retire = 1'b1;
        r.exp.rf_we = !(k == K_FEN || k == K_SYS);
        r.exp.wb_sel = (k == K_LD) ? 2'd1 : ((k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0);
        r.exp.pc_sel = (k == K_JAL || k == K_JALR) ? 2'd1 : 2'd0;
        push(r, 1'b0, 1'b0);
    endfunction

    always @(negedge clk) begin
        if (cur_valid) begin
            n_chk++;
            if (((dut_o ^ cur.exp) & cur.mask) != '0) begin
                n_fail++;
                $display("FAIL cycle id=%0d st=%0d act=%h exp=%h mask=%h",
                         cur.id, cur.exp.state, dut_o, cur.exp, cur.mask);
            end
            if (cur.lit_en) begin
                n_chk++;
                if (((dut_o ^ cur.lit) & cur.mask) != '0) begin
                    n_fail++;
                    $display("FAIL literal id=%0d act=%h exp=%h", cur.id, dut_o, cur.lit);
                end
            end
            if (cur.mid_rst) begin
                #2;
                n_chk++;
                if (dut_o != '0) begin
                    n_fail++;
                    $display("FAIL async_reset act=%h exp=%h", dut_o, 19'h0);
                end
            end
        end
    end

    task automatic run_queue();
        while (q.size() > 0) begin
            cur = q.pop_front();
            rst_n = cur.rst;
            inst = cur.ins;
            mem_ready = cur.rdy;
            br_taken = cur.br;
            cur_valid = 1'b1;
            if (cur.mid_rst) begin
                @(negedge clk);
                #1 rst_n = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        cur_valid = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        out_t l;
        @(posedge clk);
        #1;
        push_reset_idle();
        push_instr(32'h00500093, 1, 0, 1'b0, 32'h00500093);
        l = '0; l.state = 3'd5; l.pc_we = 1'b1; l.rf_we = 1'b1; l.retire = 1'b1; set_lit(l);
        q[q.size()-2].lit = '0;
        q[q.size()-2].lit.state = 3'd3;
        q[q.size()-2].lit.alu_b_sel = 1'b1;
        q[q.size()-2].lit_en = 1'b1;
        push_instr(32'h0000A103, 0, 3, 1'b0, 32'h0000A103);
        l = '0; l.state = 3'd5; l.pc_we = 1'b1; l.rf_we = 1'b1; l.wb_sel = 2'd1; l.retire = 1'b1;
        set_lit(l);
        push_instr(32'h0020A023, 0, 1, 1'b0, 32'h0020A023);
        l = '0; l.state = 3'd4; l.mem_req = 1'b1; l.mem_we = 1'b1; l.mem_addr_sel = 1'b1;
        l.pc_we = 1'b1; l.retire = 1'b1; set_lit(l);
        push_instr(32'h00208463, 0, 0, 1'b1, 32'h00208463);
        l = '0; l.state = 3'd3; l.pc_we = 1'b1; l.pc_sel = 2'd1; l.retire = 1'b1;
        l.alu_a_sel = 2'd1; l.alu_b_sel = 1'b1; set_lit(l);
        push_instr(32'h00208463, 0, 0, 1'b0, 32'h00208463);
        push_instr(32'h008000EF, 0, 0, 1'b0, 32'h0000A103);
        l = '0; l.state = 3'd5; l.pc_we = 1'b1; l.pc_sel = 2'd1; l.rf_we = 1'b1;
        l.wb_sel = 2'd2; l.retire = 1'b1; set_lit(l);
        push_instr(32'h123450B7, 0, 0, 1'b0, 32'h123450B7);
        push_instr(32'h00001097, 0, 0, 1'b0, 32'h00001097);
        push_instr(32'h000080E7, 0, 0, 1'b0, 32'h000080E7);
        push_instr(32'h002081B3, 0, 0, 1'b0, 32'h002081B3);
        push_instr(32'h0000000F, 0, 0, 1'b0, 32'h0000000F);
        push_instr(32'h00000073, 0, 0, 1'b0, 32'h00000073);
        push_instr(32'h00500093, 3, 0, 1'b0, 32'h00500093);
        push_instr(32'h00000000, 0, 0, 1'b0, 32'h00000000);
        l = '0; l.state = 3'd6; l.pc_we = 1'b1; l.pc_sel = 2'd2; l.illegal = 1'b1; set_lit(l);
        push_instr(32'h00500093, 0, 0, 1'b0, 32'h00500093);
        push_instr(32'h00500093, 4, 0, 1'b0, 32'h00500093);
        l = '0; l.state = 3'd6; l.pc_we = 1'b1; l.pc_sel = 2'd2; l.illegal = 1'b1;
        l.timeout = 1'b1; set_lit(l);
        push_instr(32'h0000A103, 0, 10, 1'b0, 32'h0000A103);
        push_instr(32'h002081B3, 0, 0, 1'b0, 32'h002081B3);
        push_instr(32'h0000A103, 0, 3, 1'b0, 32'h0000A103);
        for (int i = 0; i < 4; i++) void'(q.pop_back());
        q[$].mid_rst = 1'b1;
        push_reset_idle();
        push_instr(32'h00500093, 0, 0, 1'b0, 32'h00500093);
        run_queue();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
